// File: rtl/piezo_sound_sched_pkg.sv
// Shared encodings for the piezo sound scheduler: sources, FSM states,
// note ROM layout and 50 MHz note half-period constants.
package piezo_sound_sched_pkg;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_KEY   = 2'd1,
        SRC_CHIME = 2'd2,
        SRC_ALARM = 2'd3
    } src_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PLAY = 3'd2,
        ST_GAP  = 3'd3,
        ST_END  = 3'd4
    } state_t;

    localparam int ROM_AW = 4;

    // Each sequence ends in a {0,0} terminator entry
    localparam logic [ROM_AW-1:0] BASE_KEY   = 4'd0;
    localparam logic [ROM_AW-1:0] BASE_CHIME = 4'd2;
    localparam logic [ROM_AW-1:0] BASE_ALARM = 4'd7;

    localparam int NOTE_C6   = 23877;
    localparam int NOTE_E6   = 18953;
    localparam int NOTE_G6   = 15943;
    localparam int NOTE_C7   = 11943;
    localparam int NOTE_REST = 0;

endpackage

// File: rtl/piezo_note_rom.sv
// Combinational note table: address -> {LIMIT, DUR}. Unlisted addresses,
// including every sequence terminator, read as {0,0}.
module piezo_note_rom import piezo_sound_sched_pkg::*; #(
    parameter int LIMIT_W = 16,
    parameter int DUR_W   = 8
) (
    input  logic [ROM_AW-1:0]  addr,
    output logic [LIMIT_W-1:0] limit,
    output logic [DUR_W-1:0]   dur
);

    always_comb begin
        limit = '0;
        dur   = '0;
        case (addr)
            4'd0:  begin limit = LIMIT_W'(NOTE_C6);   dur = DUR_W'(5);  end
            4'd2:  begin limit = LIMIT_W'(NOTE_C6);   dur = DUR_W'(20); end
            4'd3:  begin limit = LIMIT_W'(NOTE_E6);   dur = DUR_W'(20); end
            4'd4:  begin limit = LIMIT_W'(NOTE_G6);   dur = DUR_W'(20); end
            4'd5:  begin limit = LIMIT_W'(NOTE_C7);   dur = DUR_W'(40); end
            4'd7:  begin limit = LIMIT_W'(NOTE_C7);   dur = DUR_W'(10); end
            4'd8:  begin limit = LIMIT_W'(NOTE_REST); dur = DUR_W'(5);  end
            4'd9:  begin limit = LIMIT_W'(NOTE_C7);   dur = DUR_W'(10); end
            4'd10: begin limit = LIMIT_W'(NOTE_REST); dur = DUR_W'(25); end
            default: ;
        endcase
    end

endmodule

// File: rtl/piezo_sound_sched.sv
// Piezo sound scheduler: arbitrates key/chime/alarm requests and plays note
// sequences. Optional MUTE input is enabled by macro PIEZO_SCHED_MUTE_EN.
//
// state | meaning
// IDLE  | silent, waiting for a pending request
// LOAD  | one cycle: latch LIMIT/DUR from ROM at the pointer
// PLAY  | tone on (unless rest) for DUR ticks
// GAP   | silent for one tick, then advance pointer
// END   | one cycle DONE pulse, back to IDLE
module piezo_sound_sched import piezo_sound_sched_pkg::*; #(
    parameter int TICK_DIV = 500000,
    parameter int LIMIT_W  = 16,
    parameter int DUR_W    = 8
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic               REQ_KEY,
    input  logic               REQ_CHIME,
    input  logic               REQ_ALARM,
    input  logic               ALARM_STOP,
`ifdef PIEZO_SCHED_MUTE_EN
    input  logic               MUTE,
`endif
    output logic               TONE_EN,
    output logic [LIMIT_W-1:0] LIMIT,
    output logic               BUSY,
    output logic [1:0]         SRC,
    output logic               DONE
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    state_t             state_q, state_d;
    src_t               src_q, src_d;
    logic [ROM_AW-1:0]  ptr_q, ptr_d;
    logic [LIMIT_W-1:0] limit_q, limit_d;
    logic [DUR_W-1:0]   tick_q, tick_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic               pend_key_q, pend_key_d;
    logic               pend_chime_q, pend_chime_d;
    logic               pend_alarm_q, pend_alarm_d;
    logic [LIMIT_W-1:0] rom_limit;
    logic [DUR_W-1:0]   rom_dur;
    logic               mute, active, alarm_go, preempt;

`ifdef PIEZO_SCHED_MUTE_EN
    assign mute = MUTE;
`else
    assign mute = 1'b0;
`endif

    piezo_note_rom #(.LIMIT_W(LIMIT_W), .DUR_W(DUR_W)) u_rom (
        .addr  (ptr_q),
        .limit (rom_limit),
        .dur   (rom_dur)
    );

    assign active   = (state_q == ST_LOAD) || (state_q == ST_PLAY) || (state_q == ST_GAP);
    assign alarm_go = (REQ_ALARM || pend_alarm_q) && !ALARM_STOP;
    assign preempt  = active && (src_q != SRC_ALARM) && alarm_go;

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        ptr_d        = ptr_q;
        limit_d      = limit_q;
        tick_d       = tick_q;
        pre_d        = pre_q;
        pend_key_d   = (pend_key_q || (REQ_KEY && !(active && src_q == SRC_KEY))) && !mute;
        pend_chime_d = (pend_chime_q || REQ_CHIME) && !mute;
        pend_alarm_d = alarm_go;

        case (state_q)
            ST_IDLE: begin
                if (pend_alarm_q && !ALARM_STOP) begin
                    state_d = ST_LOAD; src_d = SRC_ALARM; ptr_d = BASE_ALARM; pend_alarm_d = 1'b0;
                end else if (pend_chime_q && !mute) begin
                    state_d = ST_LOAD; src_d = SRC_CHIME; ptr_d = BASE_CHIME; pend_chime_d = 1'b0;
                end else if (pend_key_q && !mute) begin
                    state_d = ST_LOAD; src_d = SRC_KEY; ptr_d = BASE_KEY; pend_key_d = 1'b0;
                end
            end
            ST_LOAD: begin
                limit_d = rom_limit;
                tick_d  = rom_dur - DUR_W'(1);
                pre_d   = PRE_LAST;
                if (rom_dur != '0) begin
                    state_d = ST_PLAY;
                end else if (src_q == SRC_ALARM) begin
                    ptr_d = BASE_ALARM;
                end else begin
                    state_d = ST_END;
                end
            end
            ST_PLAY: begin
                if (pre_q == '0) begin
                    pre_d = PRE_LAST;
                    if (tick_q == '0) begin
                        state_d = ST_GAP;
                    end else begin
                        tick_d = tick_q - DUR_W'(1);
                    end
                end else begin
                    pre_d = pre_q - PRE_W'(1);
                end
            end
            ST_GAP: begin
                if (pre_q == '0) begin
                    state_d = ST_LOAD;
                    ptr_d   = ptr_q + ROM_AW'(1);
                end else begin
                    pre_d = pre_q - PRE_W'(1);
                end
            end
            ST_END:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Aborts bypass END so no DONE is raised
        if (preempt) begin
            state_d      = ST_LOAD;
            src_d        = SRC_ALARM;
            ptr_d        = BASE_ALARM;
            pend_alarm_d = 1'b0;
        end else if (active && src_q == SRC_ALARM && ALARM_STOP) begin
            state_d = ST_IDLE;
        end else if (active && src_q != SRC_ALARM && mute) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q      <= ST_IDLE;
            src_q        <= SRC_NONE;
            ptr_q        <= '0;
            limit_q      <= '0;
            tick_q       <= '0;
            pre_q        <= '0;
            pend_key_q   <= 1'b0;
            pend_chime_q <= 1'b0;
            pend_alarm_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            ptr_q        <= ptr_d;
            limit_q      <= limit_d;
            tick_q       <= tick_d;
            pre_q        <= pre_d;
            pend_key_q   <= pend_key_d;
            pend_chime_q <= pend_chime_d;
            pend_alarm_q <= pend_alarm_d;
        end
    end

    assign TONE_EN = (state_q == ST_PLAY) && (limit_q != '0);
    assign LIMIT   = limit_q;
    assign BUSY    = active;
    assign SRC     = active ? src_q : SRC_NONE;
    assign DONE    = (state_q == ST_END);

endmodule

// File: doc/piezo_sound_sched.md
Name: piezo_sound_sched

Overview:
- Sound scheduler that shares the single piezo tone generator between three requesters: key beep, hourly chime and alarm melody.
- Arbitrates pending requests by fixed priority and plays note sequences from a small ROM.
- Drives the tone generator's half-period LIMIT and a tone-enable, and times each note in ticks.
- Sits between the watch control logic (request pulses) and the piezo tone generator.

Parameters:
- TICK_DIV, 500000: CLK cycles per duration tick (10 ms at 50 MHz).
- LIMIT_W, 16: width of the LIMIT output.
- DUR_W, 8: width of a note duration field, in ticks.

Ports:
- CLK  in  1  system clock
- RESETN  in  1  reset
- REQ_KEY  in  1  one-cycle pulse; request key beep
- REQ_CHIME  in  1  one-cycle pulse; request hourly chime
- REQ_ALARM  in  1  one-cycle pulse; request alarm melody
- ALARM_STOP  in  1  one-cycle pulse; stop and clear the alarm
- TONE_EN  out  1  1 = tone generator toggles; 0 = silent, generator held in reset
- LIMIT  out  LIMIT_W  half-period count for the tone generator
- BUSY  out  1  a sequence is active
- SRC  out  2  active source: 0 none, 1 key, 2 chime, 3 alarm
- DONE  out  1  one-cycle pulse when a sequence ends normally

Behaviour:
- Reset is RESETN, synchronous, active-low; clock is CLK.
- Reset values: TONE_EN=0, LIMIT=0, BUSY=0, SRC=0, DONE=0. Pending flags, counters and FSM are cleared to IDLE.
- Pending flags: each REQ_* pulse sets its flag. A flag clears when its sequence is granted (LOAD of first note).
- Key requests arriving while the key sequence plays are dropped. Chime requests arriving while the chime plays are kept pending.
- Priority: alarm > chime > key. Grant is evaluated only in IDLE, except for alarm.
- Alarm pre-emption: REQ_ALARM during a key or chime sequence aborts it the next cycle with no DONE and enters LOAD of the alarm's first note. An aborted chime is not re-queued.
- ROM entry format: {LIMIT, DUR}.
  - LIMIT=0 marks a rest: TONE_EN=0 for that note.
  - DUR=0 terminates the sequence.
- Sequences:
  - Key: one note.
  - Chime: four notes.
  - Alarm: four notes, looping forever until ALARM_STOP.
- FSM states and transitions:
  - IDLE: a pending flag goes to LOAD.
  - LOAD (1 cycle): read ROM at the sequence pointer and register LIMIT/DUR.
    - DUR=0 goes to END, or for alarm wraps the pointer to the alarm base and reloads.
    - Otherwise goes to PLAY, with the tick counter and prescaler cleared.
  - PLAY: TONE_EN=(LIMIT!=0) for exactly DUR*TICK_DIV cycles, then goes to GAP.
  - GAP: TONE_EN=0 and LIMIT held for exactly TICK_DIV cycles; pointer increments; goes to LOAD.
  - END (1 cycle): DONE=1, BUSY=0, then goes to IDLE.
- BUSY=1 and SRC=active source in LOAD, PLAY and GAP.
- ALARM_STOP:
  - During alarm: next cycle TONE_EN=0, FSM=IDLE, alarm pending cleared, no DONE.
  - Otherwise: only clears the alarm pending flag.
- Simultaneous REQ_ALARM and ALARM_STOP: stop wins and the alarm is not started.
- Reset mid-sequence: immediate silence next cycle; all pending flags are lost.
- LIMIT changes only in LOAD, so the tone generator never sees a mid-note change.

Optional Feature:
- Macro PIEZO_SCHED_MUTE_EN adds an input MUTE (1 bit).
- With the macro, MUTE=1:
  - Key and chime requests are ignored and their pending flags cleared.
  - An active key or chime sequence is aborted as on pre-emption, with no DONE.
  - Alarm is unaffected.
- Without the macro: no MUTE port, and all requests behave as above.

Decomposition:
- Shared package holds:
  - source encodings (SRC_NONE/KEY/CHIME/ALARM);
  - FSM state encodings;
  - ROM base addresses per sequence;
  - note LIMIT constants for 50 MHz: C6=23877, E6=18953, G6=15943, C7=11943, REST=0.
- One sub-module, piezo_note_rom: a combinational address-to-{LIMIT, DUR} lookup.
- ROM contents:
  - key: {C6,5},{0,0}
  - chime: {C6,20},{E6,20},{G6,20},{C7,40},{0,0}
  - alarm: {C7,10},{REST,5},{C7,10},{REST,25},{0,0} (looping)

Test Plan:
- TICK_DIV=10, REQ_KEY pulse -> TONE_EN=1 with LIMIT=23877 for 50 cycles, a 10-cycle gap, then DONE pulse; BUSY falls with DONE, SRC=1 throughout.
- REQ_CHIME -> LIMIT sequence 23877, 18953, 15943, 11943 with PLAY lengths 200/200/200/400 cycles, each followed by a 10-cycle gap, then DONE.
- REQ_CHIME, then REQ_ALARM 30 cycles later -> next cycle LOAD with alarm LIMIT 11943, SRC=3, no DONE; the chime is never resumed.
- Alarm running 3 loops, then ALARM_STOP -> TONE_EN=0 next cycle, BUSY=0, no DONE; a later REQ_KEY plays normally.
- REQ_KEY and REQ_CHIME in the same cycle -> chime plays first, key second, two DONE pulses.
- RESETN=0 mid-chime -> next cycle all outputs at reset values; pending REQ_KEY lost; with PIEZO_SCHED_MUTE_EN, MUTE=1 plus REQ_KEY -> no tone.
